multi_ctrl: RTL and testbench
=============================

// Module: multi_ctrl
// PURPOSE
//   Multi-cycle MIPS control unit. Moore FSM that sequences the shared
//   datapath (single memory, single ALU, IR/MDR/A/B/ALUOut) across
//   FETCH/DECODE/EXECUTE/MEM/WRITEBACK steps for R-type, lw, sw, beq, j.
//   Sits between the IR opcode field and the datapath mux/enable controls.
// PARAMETERS
//   STATE_W       4   width of state register (>= 4)
//   ILLEGAL_TRAP  0   0: illegal opcode returns to FETCH; 1: enter HALT until reset
// PORTS
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous, active-low reset
//   OP         in   6  opcode, IR[31:26]; stable from DECODE to end of instruction
//   mem_ready  in   1  memory done (used only with MULTI_CTRL_MEMWAIT_EN)
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
//   MemtoReg, RegDst, RegWrite, ALUSrcA   out  1  datapath controls
//   ALUSrcB    out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//   ALUop      out  2  00 add, 01 sub, 10 use funct
//   PCSource   out  2  00 ALU result, 01 ALUOut, 10 jump target
//   state      out  STATE_W  current state (debug)
//   illegal    out  1  one-cycle pulse in DECODE on unsupported opcode
// BEHAVIOUR
//   - Reset (rst=0): state<=FETCH asynchronously; all outputs forced 0
//     while rst=0. First FETCH cycle is the first edge after release.
//   - Opcodes: R 6'h00, LW 6'h23, SW 6'h2B, BEQ 6'h04, J 6'h02.
//   - States/outputs (signals not listed are 0):
//     FETCH : MemRead IRWrite PCWrite, ALUSrcB=01               -> DECODE
//     DECODE: ALUSrcB=11                     -> MEMADR(lw/sw) EXEC(R) BEQ JUMP
//     MEMADR: ALUSrcA ALUSrcB=10                    -> MEMRD(lw) MEMWR(sw)
//     MEMRD : MemRead IorD                                       -> MEMWB
//     MEMWB : RegWrite MemtoReg                                  -> FETCH
//     MEMWR : MemWrite IorD                                      -> FETCH
//     EXEC  : ALUSrcA ALUop=10                                   -> RWB
//     RWB   : RegWrite RegDst                                    -> FETCH
//     BEQ   : ALUSrcA ALUop=01 PCWriteCond PCSource=01           -> FETCH
//     JUMP  : PCWrite PCSource=10                                -> FETCH
//     HALT  : all 0, self-loop (ILLEGAL_TRAP=1 only)
//   - Illegal opcode in DECODE: illegal=1 that cycle; next FETCH or HALT.
//   - Latency (no waits): lw 5, sw 4, R 4, beq 3, j 3 cycles.
//   - Outputs purely decoded from state (plus mem_ready under macro); no
//     output depends on OP except illegal.
//   - Unreachable state encodings -> FETCH next cycle.
//   - Reset mid-instruction abandons it; no partial RegWrite/MemWrite after
//     rst falls (outputs gated immediately).
// CONFIGURATION
//   MULTI_CTRL_MEMWAIT_EN defined: FETCH, MEMRD, MEMWR hold while
//     mem_ready=0 with MemRead/MemWrite/IorD held; IRWrite and PCWrite in
//     FETCH assert only in the cycle mem_ready=1; state advances that cycle.
//   Undefined: mem_ready ignored; every memory state lasts exactly 1 cycle.
// STRUCTURE
//   Package multi_ctrl_pkg: opcode constants, state encodings, ALUop,
//   ALUSrcB and PCSource codes (shared with datapath and bench).
//   Single module: state register + next-state logic + output decode;
//   no sub-module needed.
// TESTING
//   1 rst=0 mid-MEMRD -> outputs all 0 immediately; after release state=FETCH.
//   2 OP=6'h23 -> FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; RegWrite&MemtoReg
//     only in cycle 5.
//   3 OP=6'h2B then 6'h00 back-to-back -> 4+4 cycles; MemWrite=1 in cycle 4,
//     RegWrite&RegDst=1 in cycle 8; ALUop=10 in cycle 7.
//   4 OP=6'h04 -> 3 cycles, PCWriteCond=1 PCSource=01 ALUop=01 in cycle 3;
//     OP=6'h02 -> PCWrite=1 PCSource=10 in cycle 3.
//   5 OP=6'h3F -> illegal pulse in DECODE; ILLEGAL_TRAP=0 next FETCH,
//     ILLEGAL_TRAP=1 stays HALT, all outputs 0 until rst.
//   6 MEMWAIT_EN, lw, mem_ready low 3 cycles in FETCH and 2 in MEMRD ->
//     total 10 cycles; IRWrite/PCWrite single-cycle pulse.

Source files
------------

// File: rtl/multi_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM states,
// and the datapath mux/ALU codes used by the datapath and the bench.
package multi_ctrl_pkg;

    localparam logic [5:0] OP_R   = 6'h00;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_J   = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_HALT   = 4'd10
    } state_e;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_supported(logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multi_ctrl.sv
// Moore FSM sequencing the shared multi-cycle MIPS datapath.
// Define MULTI_CTRL_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multi_ctrl
    import multi_ctrl_pkg::*;
#(
    parameter int STATE_W      = 4,
    parameter int ILLEGAL_TRAP = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         OP,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUop,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    logic [STATE_W-1:0] state_q, state_d;
    ctrl_t              ctrl;
    ctrl_t              ctrl_g;
    logic               illegal_c;
    logic               mem_go;

`ifdef MULTI_CTRL_MEMWAIT_EN
    assign mem_go = mem_ready;
`else
    logic mem_ready_unused;
    assign mem_ready_unused = mem_ready;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= STATE_W'(S_FETCH);
        else      state_q <= state_d;
    end

    always_comb begin
        state_d   = STATE_W'(S_FETCH);
        ctrl      = '0;
        illegal_c = 1'b0;
        case (state_q)
            STATE_W'(S_FETCH): begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_go;
                ctrl.pc_write  = mem_go;
                state_d        = mem_go ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
            end
            STATE_W'(S_DECODE): begin
                ctrl.alu_src_b = SRCB_IMMSH;
                case (OP)
                    OP_LW, OP_SW: state_d = STATE_W'(S_MEMADR);
                    OP_R:         state_d = STATE_W'(S_EXEC);
                    OP_BEQ:       state_d = STATE_W'(S_BEQ);
                    OP_J:         state_d = STATE_W'(S_JUMP);
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = (ILLEGAL_TRAP != 0) ? STATE_W'(S_HALT) : STATE_W'(S_FETCH);
                    end
                endcase
            end
            STATE_W'(S_MEMADR): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (OP == OP_LW) ? STATE_W'(S_MEMRD) : STATE_W'(S_MEMWR);
            end
            STATE_W'(S_MEMRD): begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                state_d       = mem_go ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMRD);
            end
            STATE_W'(S_MEMWB): begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            STATE_W'(S_MEMWR): begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                state_d        = mem_go ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWR);
            end
            STATE_W'(S_EXEC): begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = STATE_W'(S_RWB);
            end
            STATE_W'(S_RWB): begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            STATE_W'(S_BEQ): begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            STATE_W'(S_JUMP): begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            // HALT is only a legal resting place when trapping is enabled
            STATE_W'(S_HALT): begin
                state_d = (ILLEGAL_TRAP != 0) ? STATE_W'(S_HALT) : STATE_W'(S_FETCH);
            end
            default: state_d = STATE_W'(S_FETCH);
        endcase
    end

    // Outputs drop the moment reset asserts, before the state register reacts
    assign ctrl_g      = rst ? ctrl : '0;
    assign PCWrite     = ctrl_g.pc_write;
    assign PCWriteCond = ctrl_g.pc_write_cond;
    assign IorD        = ctrl_g.i_or_d;
    assign MemRead     = ctrl_g.mem_read;
    assign MemWrite    = ctrl_g.mem_write;
    assign IRWrite     = ctrl_g.ir_write;
    assign MemtoReg    = ctrl_g.mem_to_reg;
    assign RegDst      = ctrl_g.reg_dst;
    assign RegWrite    = ctrl_g.reg_write;
    assign ALUSrcA     = ctrl_g.alu_src_a;
    assign ALUSrcB     = ctrl_g.alu_src_b;
    assign ALUop       = ctrl_g.alu_op;
    assign PCSource    = ctrl_g.pc_source;
    assign state       = rst ? state_q : '0;
    assign illegal     = rst & illegal_c;

endmodule

// File: tb/tb_multi_ctrl.sv
// Scoreboard bench for multi_ctrl: two instances (ILLEGAL_TRAP 0 and 1)
// share stimulus; expected states/controls are queued and popped each cycle.
module tb_multi_ctrl;
    import multi_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [5:0] OP  = 6'h00;
    logic       mem_ready = 1'b0;

`ifdef MULTI_CTRL_MEMWAIT_EN
    localparam bit MW = 1'b1;
`else
    localparam bit MW = 1'b0;
`endif

    logic       pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0, ill0;
    logic [1:0] sb0, aop0, pcs0;
    logic [3:0] st0;
    logic       pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1, ill1;
    logic [1:0] sb1, aop1, pcs1;
    logic [3:0] st1;

    multi_ctrl #(.STATE_W(4), .ILLEGAL_TRAP(0)) dut0 (
        .clk(clk), .rst(rst), .OP(OP), .mem_ready(mem_ready),
        .PCWrite(pcw0), .PCWriteCond(pcwc0), .IorD(iord0), .MemRead(mr0),
        .MemWrite(mw0), .IRWrite(irw0), .MemtoReg(m2r0), .RegDst(rd0),
        .RegWrite(rw0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ALUop(aop0),
        .PCSource(pcs0), .state(st0), .illegal(ill0)
    );

    multi_ctrl #(.STATE_W(4), .ILLEGAL_TRAP(1)) dut1 (
        .clk(clk), .rst(rst), .OP(OP), .mem_ready(mem_ready),
        .PCWrite(pcw1), .PCWriteCond(pcwc1), .IorD(iord1), .MemRead(mr1),
        .MemWrite(mw1), .IRWrite(irw1), .MemtoReg(m2r1), .RegDst(rd1),
        .RegWrite(rw1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ALUop(aop1),
        .PCSource(pcs1), .state(st1), .illegal(ill1)
    );

    wire [16:0] o0 = {pcw0, pcwc0, iord0, mr0, mw0, irw0, m2r0, rd0, rw0, sa0, sb0, aop0, pcs0, ill0};
    wire [16:0] o1 = {pcw1, pcwc1, iord1, mr1, mw1, irw1, m2r1, rd1, rw1, sa1, sb1, aop1, pcs1, ill1};

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] s0;
        logic [3:0] s1;
        logic       i0;
        logic       i1;
        logic       mr;
        logic       rdy;
        string      tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Control table written straight from the state/output list
    function automatic logic [16:0] model(logic [3:0] s, logic ill, logic rdy);
        logic       pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] sb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa} = '0;
        sb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            S_FETCH:  begin mr = 1'b1; irw = rdy; pcw = rdy; sb = 2'b01; end
            S_DECODE: sb = 2'b11;
            S_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            S_MEMRD:  begin mr = 1'b1; iord = 1'b1; end
            S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
            S_MEMWR:  begin mw = 1'b1; iord = 1'b1; end
            S_EXEC:   begin sa = 1'b1; aop = 2'b10; end
            S_RWB:    begin rw = 1'b1; rd = 1'b1; end
            S_BEQ:    begin sa = 1'b1; aop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
            S_JUMP:   begin pcw = 1'b1; pcs = 2'b10; end
            default:  ;
        endcase
        return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, sa, sb, aop, pcs, ill};
    endfunction

    task automatic push(input logic [3:0] s0, input logic [3:0] s1, input logic i0,
                        input logic i1, input logic mr, input logic rdy, input string tag);
        exp_t e;
        e.s0 = s0; e.s1 = s1; e.i0 = i0; e.i1 = i1; e.mr = mr; e.rdy = rdy; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_same(input logic [3:0] s, input logic ill, input string tag);
        push(s, s, ill, ill, MW, 1'b1, tag);
    endtask

    task automatic check_one();
        exp_t       e;
        logic [16:0] x0, x1;
        e = q.pop_front();
        mem_ready = e.mr;
        @(negedge clk);
        x0 = model(e.s0, e.i0, e.rdy);
        x1 = model(e.s1, e.i1, e.rdy);
        checks++;
        assert (st0 === e.s0) else begin
            errors++; $error("FAIL %s state0 got %0d exp %0d", e.tag, st0, e.s0);
        end
        checks++;
        assert (o0 === x0) else begin
            errors++; $error("FAIL %s ctrl0 got %h exp %h", e.tag, o0, x0);
        end
        checks++;
        assert (st1 === e.s1) else begin
            errors++; $error("FAIL %s state1 got %0d exp %0d", e.tag, st1, e.s1);
        end
        checks++;
        assert (o1 === x1) else begin
            errors++; $error("FAIL %s ctrl1 got %h exp %h", e.tag, o1, x1);
        end
    endtask

    task automatic drain();
        while (q.size() > 0) begin
            check_one();
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset(input string tag);
        checks++;
        assert (o0 === 17'h0 && st0 === 4'h0) else begin
            errors++; $error("FAIL %s rst0 got %h/%0d exp 0/0", tag, o0, st0);
        end
        checks++;
        assert (o1 === 17'h0 && st1 === 4'h0) else begin
            errors++; $error("FAIL %s rst1 got %h/%0d exp 0/0", tag, o1, st1);
        end
    endtask

    initial begin
        mem_ready = MW;
        repeat (2) @(posedge clk);
        #1 check_reset("por");
        @(posedge clk); #1 rst = 1'b1;

        // lw: 5 cycles
        OP = OP_LW;
        push_same(S_FETCH, 1'b0, "lw1");  push_same(S_DECODE, 1'b0, "lw2");
        push_same(S_MEMADR, 1'b0, "lw3"); push_same(S_MEMRD, 1'b0, "lw4");
        push_same(S_MEMWB, 1'b0, "lw5");
        drain();

        // sw then R back-to-back
        OP = OP_SW;
        push_same(S_FETCH, 1'b0, "sw1");  push_same(S_DECODE, 1'b0, "sw2");
        push_same(S_MEMADR, 1'b0, "sw3"); push_same(S_MEMWR, 1'b0, "sw4");
        drain();
        OP = OP_R;
        push_same(S_FETCH, 1'b0, "r1");   push_same(S_DECODE, 1'b0, "r2");
        push_same(S_EXEC, 1'b0, "r3");    push_same(S_RWB, 1'b0, "r4");
        drain();

        // beq and j
        OP = OP_BEQ;
        push_same(S_FETCH, 1'b0, "beq1"); push_same(S_DECODE, 1'b0, "beq2");
        push_same(S_BEQ, 1'b0, "beq3");
        drain();
        OP = OP_J;
        push_same(S_FETCH, 1'b0, "j1");   push_same(S_DECODE, 1'b0, "j2");
        push_same(S_JUMP, 1'b0, "j3");
        drain();

        // illegal: dut0 resumes fetching, dut1 parks in HALT
        OP = 6'h3F;
        push_same(S_FETCH, 1'b0, "ill1"); push_same(S_DECODE, 1'b1, "ill2");
        drain();
        OP = OP_J;
        push(S_FETCH,  S_HALT, 1'b0, 1'b0, MW, 1'b1, "halt1");
        push(S_DECODE, S_HALT, 1'b0, 1'b0, MW, 1'b1, "halt2");
        push(S_JUMP,   S_HALT, 1'b0, 1'b0, MW, 1'b1, "halt3");
        push(S_FETCH,  S_HALT, 1'b0, 1'b0, MW, 1'b1, "halt4");
        drain();
        rst = 1'b0;
        #1 check_reset("halt_rst");
        @(posedge clk); #1 rst = 1'b1;

        // reset asserted in the middle of MEMRD
        OP = OP_LW;
        push_same(S_FETCH, 1'b0, "mid1"); push_same(S_DECODE, 1'b0, "mid2");
        push_same(S_MEMADR, 1'b0, "mid3");
        drain();
        push_same(S_MEMRD, 1'b0, "mid4");
        check_one();
        #1 rst = 1'b0;
        #1 check_reset("mid_rst_now");
        @(posedge clk); #1 check_reset("mid_rst_hold");
        @(posedge clk); #1 rst = 1'b1;
        OP = OP_J;
        push_same(S_FETCH, 1'b0, "post1"); push_same(S_DECODE, 1'b0, "post2");
        push_same(S_JUMP, 1'b0, "post3");  push_same(S_FETCH, 1'b0, "post4");
        drain();

`ifdef MULTI_CTRL_MEMWAIT_EN
        // lw with 3 wait cycles in FETCH and 2 in MEMRD: 10 cycles
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        OP = OP_LW;
        push(S_FETCH, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, "mw1");
        push(S_FETCH, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, "mw2");
        push(S_FETCH, S_FETCH, 1'b0, 1'b0, 1'b0, 1'b0, "mw3");
        push(S_FETCH, S_FETCH, 1'b0, 1'b0, 1'b1, 1'b1, "mw4");
        push_same(S_DECODE, 1'b0, "mw5"); push_same(S_MEMADR, 1'b0, "mw6");
        push(S_MEMRD, S_MEMRD, 1'b0, 1'b0, 1'b0, 1'b1, "mw7");
        push(S_MEMRD, S_MEMRD, 1'b0, 1'b0, 1'b0, 1'b1, "mw8");
        push(S_MEMRD, S_MEMRD, 1'b0, 1'b0, 1'b1, 1'b1, "mw9");
        push_same(S_MEMWB, 1'b0, "mw10");
        push_same(S_FETCH, 1'b0, "mw11");
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
